// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, flush squashing
// and saturating stall/flush performance counters.
module if_id_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc_in,
    input  logic [31:0]      instr_in,
    input  logic             flush,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    output logic             stall,
    output logic             bubble,
    output logic [31:0]      npc_out,
    output logic [31:0]      instr_out,
    output logic             valid_out,
    output logic [4:0]       rs_out,
    output logic [4:0]       rt_out,
    output logic [4:0]       rd_out,
    output logic [31:0]      imm_ext,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic hazard;

    assign rs_out  = instr_out[25:21];
    assign rt_out  = instr_out[20:16];
    assign rd_out  = instr_out[15:11];
    assign imm_ext = {{16{instr_out[15]}}, instr_out[15:0]};

    // Gating on valid_out keeps a squashed slot from ever holding the pipe.
    assign hazard = valid_out && ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == rs_out) || (ex_rt == rt_out));
    assign stall  = hazard && !flush;
    assign bubble = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            npc_out   <= 32'd0;
            instr_out <= 32'd0;
            valid_out <= 1'b0;
        end else if (flush) begin
            npc_out   <= 32'd0;
            instr_out <= 32'd0;
            valid_out <= 1'b0;
        end else if (!stall) begin
            npc_out   <= npc_in;
            instr_out <= instr_in;
            valid_out <= 1'b1;
        end
    end

    // Counters saturate at all-ones so long runs never wrap back to small values.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
